// File: rtl/bitmap_pixel_fetch.sv
// Bitmap video fetch: scrolls/flips the raster position into a VRAM byte address,
// reads the byte and emits one 4-bit colour nibble per pixel enable.
module bitmap_pixel_fetch #(
  parameter int LAT = 3
) (
  input  logic        CLK10,
  input  logic        RESET,
  input  logic        PIXCE,
  input  logic [8:0]  HCOUNT,
  input  logic [7:0]  VCOUNT,
  input  logic        HBLANK,
  input  logic        VBLANK,
  input  logic [7:0]  HSCRL_IN,
  input  logic [7:0]  VSCRL_IN,
  input  logic        FLIP,
  output logic [14:0] VRAM_ADDR,
  output logic        VRAM_REQ,
  input  logic [7:0]  VRAM_DATA,
  output logic [3:0]  PIX,
  output logic        PIXVALID
);

  logic [7:0]     hs_q, hs_d, vs_q, vs_d;
  logic           vblank_q, vblank_d;
  logic [14:0]    addr_q, addr_d;
  logic           req_q, req_d;
  logic           nib1_q, nib1_d, act1_q, act1_d;
  logic [LAT-2:0] pce_dly_q, pce_dly_d;
  logic [7:0]     data_q, data_d;
  logic           nib2_q, nib2_d, act2_q, act2_d;
  logic [3:0]     pix_q, pix_d;
  logic           pixvalid_q, pixvalid_d;

  logic [7:0]     x_sum_s, y_sum_s, x_s, y_s;
  logic           act_new_s;
  logic           unused_hcount_msb;

  assign unused_hcount_msb = HCOUNT[8];

  // Next-state logic for scroll shadows and the three pipeline stages
  always_comb begin
    vblank_d = VBLANK;
    if (VBLANK && !vblank_q) begin
      hs_d = HSCRL_IN;
      vs_d = VSCRL_IN;
    end else begin
      hs_d = hs_q;
      vs_d = vs_q;
    end

    // Scroll uses the current shadows, so a same-cycle VBLANK rise affects only later pixels
    x_sum_s   = HCOUNT[7:0] + hs_q;
    y_sum_s   = VCOUNT + vs_q;
    x_s       = FLIP ? ~x_sum_s : x_sum_s;
    y_s       = FLIP ? ~y_sum_s : y_sum_s;
    act_new_s = ~(HBLANK | VBLANK);

    if (PIXCE) begin
      addr_d = {y_s, x_s[7:1]};
      nib1_d = x_s[0];
      act1_d = act_new_s;
      req_d  = act_new_s;
    end else begin
      addr_d = addr_q;
      nib1_d = nib1_q;
      act1_d = act1_q;
      req_d  = 1'b0;
    end

    // RAM data is valid the cycle after the address slot; capture at the end of it
    pce_dly_d = {pce_dly_q[LAT-3:0], PIXCE};
    if (pce_dly_q[LAT-2]) begin
      data_d = VRAM_DATA;
      nib2_d = nib1_q;
      act2_d = act1_q;
    end else begin
      data_d = data_q;
      nib2_d = nib2_q;
      act2_d = act2_q;
    end

    if (PIXCE) begin
      pix_d      = act2_q ? (nib2_q ? data_q[3:0] : data_q[7:4]) : 4'h0;
      pixvalid_d = act2_q;
    end else begin
      pix_d      = pix_q;
      pixvalid_d = pixvalid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK10) begin
    if (RESET) begin
      hs_q       <= 8'h00;
      vs_q       <= 8'h00;
      vblank_q   <= 1'b1;
      addr_q     <= 15'h0000;
      req_q      <= 1'b0;
      nib1_q     <= 1'b0;
      act1_q     <= 1'b0;
      pce_dly_q  <= '0;
      data_q     <= 8'h00;
      nib2_q     <= 1'b0;
      act2_q     <= 1'b0;
      pix_q      <= 4'h0;
      pixvalid_q <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      vblank_q   <= vblank_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      nib1_q     <= nib1_d;
      act1_q     <= act1_d;
      pce_dly_q  <= pce_dly_d;
      data_q     <= data_d;
      nib2_q     <= nib2_d;
      act2_q     <= act2_d;
      pix_q      <= pix_d;
      pixvalid_q <= pixvalid_d;
    end
  end

  assign VRAM_ADDR = addr_q;
  assign VRAM_REQ  = req_q;
  assign PIX       = pix_q;
  assign PIXVALID  = pixvalid_q;

endmodule

// File: tb/tb_bitmap_pixel_fetch.sv
// Scoreboard bench for bitmap_pixel_fetch: a reference model predicts address,
// request and the delayed pixel for every pixel enable.
module tb_bitmap_pixel_fetch;

  logic        CLK10 = 1'b0;
  logic        RESET, PIXCE, HBLANK, VBLANK, FLIP;
  logic [8:0]  HCOUNT;
  logic [7:0]  VCOUNT, HSCRL_IN, VSCRL_IN, vram_data;
  logic [14:0] VRAM_ADDR;
  logic        VRAM_REQ, PIXVALID;
  logic [3:0]  PIX;

  logic [7:0]  ram [0:32767];
  logic [4:0]  sb [$];
  logic [7:0]  hs_m, vs_m;
  logic        vb_prev_m;
  logic [14:0] last_addr;
  logic [4:0]  last_out;
  int          checks = 0;
  int          failures = 0;

  bitmap_pixel_fetch #(.LAT(3)) dut (
    .CLK10(CLK10), .RESET(RESET), .PIXCE(PIXCE), .HCOUNT(HCOUNT), .VCOUNT(VCOUNT),
    .HBLANK(HBLANK), .VBLANK(VBLANK), .HSCRL_IN(HSCRL_IN), .VSCRL_IN(VSCRL_IN),
    .FLIP(FLIP), .VRAM_ADDR(VRAM_ADDR), .VRAM_REQ(VRAM_REQ), .VRAM_DATA(vram_data),
    .PIX(PIX), .PIXVALID(PIXVALID)
  );

  always #50 CLK10 = ~CLK10;

  // Synchronous-read bitmap RAM: data valid one cycle after the address
  always @(posedge CLK10) vram_data <= ram[VRAM_ADDR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hs_m = 8'h00; vs_m = 8'h00; vb_prev_m = 1'b1;
    sb.delete();
    sb.push_back(5'h00);
    sb.push_back(5'h00);
    last_addr = 15'h0000;
    last_out  = 5'h00;
  endtask

  // One CLK10 cycle; on a pixel-enable cycle the model predicts all outputs
  task automatic step(input logic pce);
    logic [7:0]  x, y, d;
    logic        act;
    logic [14:0] ea;
    logic [4:0]  got;
    PIXCE = pce;
    x = HCOUNT[7:0] + hs_m;
    y = VCOUNT + vs_m;
    if (FLIP) begin x = 8'hFF - x; y = 8'hFF - y; end
    act = ~(HBLANK | VBLANK);
    ea  = {y, x[7:1]};
    d   = ram[ea];
    if (pce) sb.push_back(act ? {1'b1, (x[0] ? d[3:0] : d[7:4])} : 5'h00);
    @(posedge CLK10);
    #1;
    if (VBLANK && !vb_prev_m) begin hs_m = HSCRL_IN; vs_m = VSCRL_IN; end
    vb_prev_m = VBLANK;
    if (pce) begin
      check("addr", VRAM_ADDR, ea);
      check("req", VRAM_REQ, act);
      last_addr = ea;
      last_out  = sb.pop_front();
      got = {PIXVALID, PIX};
      check("pix", got, last_out);
    end else begin
      check("req_idle", VRAM_REQ, 1'b0);
      check("addr_hold", VRAM_ADDR, last_addr);
      got = {PIXVALID, PIX};
      check("pix_hold", got, last_out);
    end
  endtask

  task automatic pixel(input logic [8:0] h, input logic [7:0] v, input logic hb, input logic vb);
    HCOUNT = h; VCOUNT = v; HBLANK = hb; VBLANK = vb;
    step(1'b1);
    step(1'b0);
  endtask

  task automatic do_reset();
    RESET = 1'b1; PIXCE = 1'b1;
    @(posedge CLK10);
    #1;
    RESET = 1'b0; PIXCE = 1'b0;
    check("rst_addr", VRAM_ADDR, 15'h0000);
    check("rst_req", VRAM_REQ, 1'b0);
    check("rst_pix", PIX, 4'h0);
    check("rst_valid", PIXVALID, 1'b0);
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
    RESET = 1'b1; PIXCE = 1'b0; HCOUNT = 9'h000; VCOUNT = 8'h00; HBLANK = 1'b0;
    VBLANK = 1'b0; HSCRL_IN = 8'h00; VSCRL_IN = 8'h00; FLIP = 1'b0;
    @(posedge CLK10); #1;
    do_reset();

    // Plain fetch, both nibbles of one byte
    ram[15'h1008] = 8'hA5;
    pixel(9'h010, 8'h20, 1'b0, 1'b0);
    check("addr_1008", VRAM_ADDR, 15'h1008);
    pixel(9'h011, 8'h20, 1'b0, 1'b0);
    pixel(9'h112, 8'h20, 1'b0, 1'b0);
    check("pix_hi_A", PIX, 4'hA);
    pixel(9'h013, 8'h20, 1'b0, 1'b0);
    check("pix_lo_5", PIX, 4'h5);

    // Scroll wrap on both axes
    HSCRL_IN = 8'hF8; VSCRL_IN = 8'h01;
    pixel(9'h100, 8'hF0, 1'b1, 1'b1);
    pixel(9'h00A, 8'hFF, 1'b0, 1'b0);
    check("addr_wrap", VRAM_ADDR, 15'h0001);

    // Flip with zero scroll
    HSCRL_IN = 8'h00; VSCRL_IN = 8'h00;
    pixel(9'h100, 8'hF0, 1'b0, 1'b1);
    FLIP = 1'b1; ram[15'h7FFF] = 8'h3C;
    pixel(9'h000, 8'h00, 1'b0, 1'b0);
    check("addr_flip", VRAM_ADDR, 15'h7FFF);
    pixel(9'h001, 8'h00, 1'b0, 1'b0);
    pixel(9'h002, 8'h00, 1'b0, 1'b0);
    check("pix_flip", PIX, 4'hC);
    FLIP = 1'b0;

    // Horizontally blanked pixel over 0xFF data
    ram[15'h0A20] = 8'hFF;
    pixel(9'h040, 8'h14, 1'b1, 1'b0);
    check("req_blank", VRAM_REQ, 1'b0);
    pixel(9'h041, 8'h14, 1'b0, 1'b0);
    pixel(9'h042, 8'h14, 1'b0, 1'b0);
    check("valid_blank", PIXVALID, 1'b0);

    // Mid-frame scroll write is deferred to the next VBLANK rise
    HSCRL_IN = 8'h40;
    pixel(9'h020, 8'h10, 1'b0, 1'b0);
    check("addr_noscroll", VRAM_ADDR, 15'h0810);
    pixel(9'h100, 8'h10, 1'b0, 1'b1);
    pixel(9'h020, 8'h10, 1'b0, 1'b0);
    check("addr_newscroll", VRAM_ADDR, 15'h0830);

    // Reset with the pipeline full
    pixel(9'h030, 8'h11, 1'b0, 1'b0);
    pixel(9'h031, 8'h11, 1'b0, 1'b0);
    do_reset();
    pixel(9'h032, 8'h11, 1'b0, 1'b0);
    pixel(9'h033, 8'h11, 1'b0, 1'b0);
    check("valid_after_2", PIXVALID, 1'b0);
    pixel(9'h034, 8'h11, 1'b0, 1'b0);
    check("valid_after_3", PIXVALID, 1'b1);

    // Random raster traffic with scroll reloads and flips
    for (int i = 0; i < 300; i++) begin
      if (i % 37 == 0) begin HSCRL_IN = 8'($urandom); VSCRL_IN = 8'($urandom); end
      if (i % 53 == 0) FLIP = ~FLIP;
      pixel(9'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
            ((i % 40) >= 36));
    end

    // Pixel enable stuck low
    for (int i = 0; i < 8; i++) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
